// File: rtl/dac_pkg.sv
// Shared types and command-word layout for the galvo DAC point sequencer.
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ACK   = 3'd2,
    DONE  = 3'd3,
    GAP   = 3'd4,
    LDAC  = 3'd5
  } state_t;

  localparam int CH_BIT       = 15;
  localparam int BUF_BIT      = 14;
  localparam int GA_BIT       = 13;
  localparam int SHDN_BIT     = 12;
  localparam int DAC_WORD_LEN = 16;

endpackage

// File: rtl/dac_point_sequencer.sv
// Takes one X/Y point per handshake, sends channel A then channel B command
// words through the spi master, then strobes LDAC so both axes move together.
module dac_point_sequencer
  import dac_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned LDAC_CYCLES = 2,
  parameter int unsigned BUFFERED    = 0,
  parameter int unsigned GAIN_1X     = 1
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        point_valid_in,
  output logic        point_ready_out,
  output logic [15:0] spi_data_out,
  output logic [5:0]  spi_data_length_out,
  output logic        spi_start_out,
  input  logic        spi_busy_in,
  output logic        ldac_out,
  output logic        busy_out,
  output logic [2:0]  state_out
);

  // Handshake: a point transfers on a rising clock_in edge where
  // point_valid_in && point_ready_out; ready is high only in IDLE.

  state_t      state;
  logic        channel;
  logic [11:0] y_q;
  logic [7:0]  cnt;

  assign spi_data_length_out = 6'(DAC_WORD_LEN);
  assign state_out           = state;

  function automatic logic [15:0] cmd_word(input logic ch, input logic [11:0] sample);
    logic [15:0] w;
    w           = '0;
    w[CH_BIT]   = ch;
    w[BUF_BIT]  = BUFFERED[0];
    w[GA_BIT]   = GAIN_1X[0];
    w[SHDN_BIT] = 1'b1;
    w[11:0]     = sample;
    return w;
  endfunction

  // Outputs are loaded on the transition into a state so they are valid for
  // the whole duration of that state (start high exactly while in START).
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state           <= IDLE;
      point_ready_out <= 1'b1;
      spi_start_out   <= 1'b0;
      spi_data_out    <= '0;
      ldac_out        <= 1'b1;
      busy_out        <= 1'b0;
      channel         <= 1'b0;
      y_q             <= '0;
      cnt             <= '0;
    end else begin
      spi_start_out <= 1'b0;
      case (state)
        IDLE: begin
          if (point_valid_in && point_ready_out) begin
            y_q             <= y_in;
            channel         <= 1'b0;
            spi_data_out    <= cmd_word(1'b0, x_in);
            spi_start_out   <= 1'b1;
            point_ready_out <= 1'b0;
            busy_out        <= 1'b1;
            state           <= START;
          end
        end
        START: state <= ACK;
        ACK: begin
          if (spi_busy_in) state <= DONE;
        end
        DONE: begin
          if (!spi_busy_in) begin
            cnt   <= 8'(GAP_CYCLES);
            state <= GAP;
          end
        end
        GAP: begin
          if (cnt <= 8'd1) begin
            if (!channel) begin
              channel       <= 1'b1;
              spi_data_out  <= cmd_word(1'b1, y_q);
              spi_start_out <= 1'b1;
              state         <= START;
            end else begin
              cnt      <= 8'(LDAC_CYCLES);
              ldac_out <= 1'b0;
              state    <= LDAC;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LDAC: begin
          if (cnt <= 8'd1) begin
            ldac_out        <= 1'b1;
            point_ready_out <= 1'b1;
            busy_out        <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state           <= IDLE;
          point_ready_out <= 1'b1;
          busy_out        <= 1'b0;
          ldac_out        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dac_point_sequencer.md
Name: dac_point_sequencer

Overview:
- Upstream feeder for the `spi` master; drives a dual-channel 12-bit galvo DAC (MCP4922-style command words).
- Accepts one X/Y point per valid/ready handshake and packs two 16-bit command words (channel A = X, channel B = Y).
- Issues each word as a separate `spi` transaction through `spi`'s start/busy interface.
- After both words, pulses active-low LDAC so both galvo axes update simultaneously.

Parameters:
- GAP_CYCLES, 4: idle cycles between the end of one SPI transaction and the next action (CS-high time); range 1..255.
- LDAC_CYCLES, 2: width of the LDAC low pulse in clock cycles; range 1..255.
- BUFFERED, 0: value of command bit 14 (VREF buffer).
- GAIN_1X, 1: value of command bit 13 (GA_n; 1 = 1x gain).

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  synchronous, active-high reset
- x_in  input  12  X sample, DAC channel A
- y_in  input  12  Y sample, DAC channel B
- point_valid_in  input  1  point offered
- point_ready_out  output  1  sequencer can accept a point
- spi_data_out  output  16  command word to spi data_in
- spi_data_length_out  output  6  constant 16, to spi data_length_in
- spi_start_out  output  1  one-cycle start pulse to spi start_in
- spi_busy_in  input  1  from spi busy_out
- ldac_out  output  1  DAC latch strobe, active low
- busy_out  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active high):
  - state = IDLE; point_ready_out = 1; spi_start_out = 0; spi_data_out = 0; ldac_out = 1; busy_out = 0.
  - Reset during any state aborts immediately to IDLE; a captured point is discarded.
  - An in-flight spi transaction is left to finish on its own; it is never re-issued.
- Command word format:
  - bit15 = channel (0 = A, 1 = B); bit14 = BUFFERED; bit13 = GAIN_1X; bit12 = 1 (SHDN_n, active); bits11:0 = sample.
  - With defaults: A word = 16'h3000 | x, B word = 16'hB000 | y.
- Point acceptance:
  - point_ready_out = (state == IDLE), registered.
  - A handshake (valid && ready) captures x_in and y_in into internal registers and moves to START with channel = A.
  - Inputs are ignored outside IDLE. No buffering beyond one point.
- States:
  - IDLE:
    - ready high; wait for handshake.
  - START:
    - spi_data_out = word for the current channel; spi_start_out = 1 for exactly this one cycle; go to ACK.
    - spi_data_out holds its value through ACK and DONE.
  - ACK:
    - Wait for spi_busy_in = 1, then go to DONE.
    - If spi_busy_in is already 1 in the first ACK cycle, move to DONE next cycle.
  - DONE:
    - Wait for spi_busy_in = 0, then load the counter with GAP_CYCLES and go to GAP.
  - GAP:
    - Decrement the counter. At zero: if channel = A, set channel = B and go to START; if channel = B, load the counter with LDAC_CYCLES and go to LDAC.
  - LDAC:
    - ldac_out = 0; decrement the counter. At zero, ldac_out returns to 1, state = IDLE, ready = 1.
- Latency:
  - Handshake at cycle N gives spi_start_out high at cycle N+1.
  - Cycle count from handshake to ready high again = 2 × (1 + spi_time + GAP_CYCLES) + LDAC_CYCLES + ~2, where spi_time is the number of cycles spi_busy_in stays high.
- spi_data_length_out is a constant 6'd16 and is not affected by reset.
- Single 8-bit down-counter shared by GAP and LDAC.
- Boundary conditions:
  - point_valid_in held high across completion: the next point is accepted in the first IDLE cycle.
  - x/y = 12'hFFF and 12'h000 are passed unchanged. There is no overflow because the sample fields are fixed at 12 bits.

Decomposition:
- Shared package `dac_pkg`:
  - state enum typedef (IDLE, START, ACK, DONE, GAP, LDAC);
  - command bit-position constants (CH_BIT = 15, BUF_BIT = 14, GA_BIT = 13, SHDN_BIT = 12);
  - DAC_WORD_LEN = 16.
- No sub-module: word packing is a single concatenation and the counter is inline.
- The bench instantiates this block with the real `spi` (PRESCALER = 10).

Test Plan:
- Basic point: after reset, present x = 12'hABC, y = 12'h123 with valid for one cycle → spi_start pulse with spi_data_out = 16'h3ABC; after busy falls plus 4 gap cycles, start pulse with 16'hB123; after a further gap, ldac_out low for exactly 2 cycles; then ready high. Checker decodes mosi/sclk: 0x3ABC then 0xB123, each a full 16-bit frame with cs high between them.
- Back-to-back points: valid held high with points (0x000, 0xFFF) then (0xFFF, 0x000) → words 3000, BFFF, 3FFF, B000 in order. Exactly two LDAC pulses; each second point is accepted on the cycle ready rises.
- Backpressure: assert valid while busy with a different x → value not captured; sent only after it is re-presented in IDLE.
- Reset mid-operation: assert reset during DONE of channel B → next cycle state is IDLE, ldac_out = 1, no LDAC pulse, ready = 1. A new point afterwards sends both words correctly.
- Parameter corner: GAP_CYCLES = 1, LDAC_CYCLES = 1, BUFFERED = 1, GAIN_1X = 0 → words 16'h5000 | x and 16'hD000 | y; ldac low for a single cycle.
- Fast-busy model: replace `spi` with a stub that asserts busy in the same cycle as start and holds it 3 cycles → the sequencer still issues exactly two starts per point, with no double start.
